imm_decode_queue: RTL and testbench

Two-entry decode buffer between instruction fetch and the immediate generator. Accepts fetched instructions over a valid/ready handshake, classifies each opcode into the 4-bit immediate-select code, and stores the instruction, PC and select code together. Presents the oldest entry to the decode stage, so the instruction and the `SELECT` input of the immediate generator are always stable while the entry is stalled. Also provides flush on branch redirect and a saturating stall counter for performance monitoring.

---
 rtl/imm_decode_queue.sv | 156 +++++++++++++++
 tb/tb_imm_decode_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_queue.sv
// Two-entry decode buffer between fetch and the immediate generator.
// The opcode is classified when the entry is pushed, so the immediate-select code presented to decode always comes from registers.
module imm_decode_queue #(
   parameter int DEPTH   = 2,
   parameter int STALL_W = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               IF_VALID,
   input  logic [31:0]        IF_INSTRUCTION,
   input  logic [31:0]        IF_PC,
   output logic               IF_READY,
   input  logic               FLUSH,
   input  logic               ID_READY,
   output logic               ID_VALID,
   output logic [31:0]        ID_INSTRUCTION,
   output logic [31:0]        ID_PC,
   output logic [3:0]         IMM_SEL,
   output logic               IMM_EN,
   output logic               ILLEGAL,
   output logic [STALL_W-1:0] STALL_CNT
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  sel;
      logic        en;
      logic        ill;
   } entry_t;

   localparam entry_t ENTRY_RST = '{instr: 32'd0, pc: 32'd0, sel: 4'b0111, en: 1'b0, ill: 1'b0};

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [1:0]         count_reg, count_next;
   logic               rd_ptr_reg, rd_ptr_next;
   logic               wr_ptr_reg, wr_ptr_next;
   entry_t             head_reg, head_next;
   logic [STALL_W-1:0] stall_reg, stall_next;
   entry_t             in_entry;
   entry_t             slots [DEPTH];
   logic               push, pop;

   assign IF_READY = (count_reg != 2'd2);
   assign ID_VALID = (count_reg != 2'd0);
   assign push     = IF_VALID & IF_READY & ~FLUSH;
   assign pop      = ID_VALID & ID_READY & ~FLUSH;

   always_comb begin
      in_entry       = ENTRY_RST;
      in_entry.instr = IF_INSTRUCTION;
      in_entry.pc    = IF_PC;
      case (IF_INSTRUCTION[6:0])
         OPC_LUI, OPC_AUIPC: begin
            in_entry.sel = 4'b0000;
            in_entry.en  = 1'b1;
         end
         OPC_JAL: begin
            in_entry.sel = 4'b0001;
            in_entry.en  = 1'b1;
         end
         OPC_OP_IMM: begin
            // SLTIU compares against the immediate as unsigned
            in_entry.sel = {IF_INSTRUCTION[14:12] == 3'b011, 3'b010};
            in_entry.en  = 1'b1;
         end
         OPC_LOAD, OPC_JALR: begin
            in_entry.sel = 4'b0010;
            in_entry.en  = 1'b1;
         end
         OPC_BRANCH: begin
            in_entry.sel = {IF_INSTRUCTION[14:13] == 2'b11, 3'b011};
            in_entry.en  = 1'b1;
         end
         OPC_STORE: begin
            in_entry.sel = 4'b0100;
            in_entry.en  = 1'b1;
         end
         OPC_OP: ;
         default: in_entry.ill = 1'b1;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         entry_t slot_reg;
         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               slot_reg <= ENTRY_RST;
            end else if (push && (int'(wr_ptr_reg) == gi)) begin
               slot_reg <= in_entry;
            end
         end
         assign slots[gi] = slot_reg;
      end
   endgenerate

   always_comb begin
      count_next  = count_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      head_next   = head_reg;
      stall_next  = stall_reg;
      if (FLUSH) begin
         count_next  = 2'd0;
         rd_ptr_next = 1'b0;
         wr_ptr_next = 1'b0;
         stall_next  = '0;
      end else begin
         if (push) wr_ptr_next = ~wr_ptr_reg;
         if (pop)  rd_ptr_next = ~rd_ptr_reg;
         if (push && !pop)      count_next = count_reg + 2'd1;
         else if (pop && !push) count_next = count_reg - 2'd1;
         if (ID_VALID && !ID_READY && (stall_reg != '1)) stall_next = stall_reg + 1'b1;
         // The new head may be the entry being written at this very edge
         if (count_next != 2'd0) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) head_next = in_entry;
            else                                     head_next = slots[rd_ptr_next];
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count_reg  <= 2'd0;
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         head_reg   <= ENTRY_RST;
         stall_reg  <= '0;
      end else begin
         count_reg  <= count_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         head_reg   <= head_next;
         stall_reg  <= stall_next;
      end
   end

   assign ID_INSTRUCTION = head_reg.instr;
   assign ID_PC          = head_reg.pc;
   assign IMM_SEL        = head_reg.sel;
   assign IMM_EN         = head_reg.en;
   assign ILLEGAL        = head_reg.ill;
   assign STALL_CNT      = stall_reg;

endmodule

// File: tb/tb_imm_decode_queue.sv
// Directed bench for imm_decode_queue: a queue of expected entries is filled on accepted pushes
// and compared against the head on every pop and after every edge.
module tb_imm_decode_queue;

   localparam int STALL_W   = 4;
   localparam int STALL_MAX = (1 << STALL_W) - 1;

   logic               CLK = 1'b0;
   logic               RESET;
   logic               IF_VALID;
   logic [31:0]        IF_INSTRUCTION;
   logic [31:0]        IF_PC;
   logic               IF_READY;
   logic               FLUSH;
   logic               ID_READY;
   logic               ID_VALID;
   logic [31:0]        ID_INSTRUCTION;
   logic [31:0]        ID_PC;
   logic [3:0]         IMM_SEL;
   logic               IMM_EN;
   logic               ILLEGAL;
   logic [STALL_W-1:0] STALL_CNT;

   imm_decode_queue #(.DEPTH(2), .STALL_W(STALL_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .IF_VALID(IF_VALID), .IF_INSTRUCTION(IF_INSTRUCTION), .IF_PC(IF_PC), .IF_READY(IF_READY),
      .FLUSH(FLUSH), .ID_READY(ID_READY), .ID_VALID(ID_VALID),
      .ID_INSTRUCTION(ID_INSTRUCTION), .ID_PC(ID_PC), .IMM_SEL(IMM_SEL),
      .IMM_EN(IMM_EN), .ILLEGAL(ILLEGAL), .STALL_CNT(STALL_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  sel;
      logic        en;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   exp_t offered;
   int   exp_stall = 0;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_head(input string tag);
      chk({tag, "_instr"}, 64'(ID_INSTRUCTION), 64'(sb[0].instr));
      chk({tag, "_pc"},    64'(ID_PC),          64'(sb[0].pc));
      chk({tag, "_sel"},   64'(IMM_SEL),        64'(sb[0].sel));
      chk({tag, "_en"},    64'(IMM_EN),         64'(sb[0].en));
      chk({tag, "_ill"},   64'(ILLEGAL),        64'(sb[0].ill));
   endtask

   task automatic check_reset_values();
      chk("rst_id_valid", 64'(ID_VALID),       64'(0));
      chk("rst_if_ready", 64'(IF_READY),       64'(1));
      chk("rst_instr",    64'(ID_INSTRUCTION), 64'(0));
      chk("rst_pc",       64'(ID_PC),          64'(0));
      chk("rst_sel",      64'(IMM_SEL),        64'(4'b0111));
      chk("rst_en",       64'(IMM_EN),         64'(0));
      chk("rst_ill",      64'(ILLEGAL),        64'(0));
      chk("rst_stall",    64'(STALL_CNT),      64'(0));
   endtask

   task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [3:0] sel, input logic en, input logic ill);
      IF_VALID       = 1'b1;
      IF_INSTRUCTION = instr;
      IF_PC          = pc;
      offered        = '{instr: instr, pc: pc, sel: sel, en: en, ill: ill};
   endtask

   // One clock: update the model from the inputs being driven, take the edge, then check.
   task automatic cycle();
      logic do_push, do_pop, stall;
      do_push = IF_VALID && (sb.size() != 2) && !FLUSH;
      do_pop  = (sb.size() != 0) && ID_READY && !FLUSH;
      stall   = (sb.size() != 0) && !ID_READY && !FLUSH;
      if (do_pop) begin
         check_head("pop");
         $display("pop   pc=%h instr=%h sel=%b en=%b ill=%b", ID_PC, ID_INSTRUCTION, IMM_SEL, IMM_EN, ILLEGAL);
         void'(sb.pop_front());
      end
      if (do_push) begin
         sb.push_back(offered);
         $display("push  pc=%h instr=%h", offered.pc, offered.instr);
      end
      if (FLUSH) begin
         sb.delete();
         exp_stall = 0;
         $display("flush");
      end else if (stall && exp_stall != STALL_MAX) begin
         exp_stall++;
      end
      @(posedge CLK);
      #1;
      chk("id_valid", 64'(ID_VALID), 64'(sb.size() != 0));
      chk("if_ready", 64'(IF_READY), 64'(sb.size() != 2));
      chk("stall_cnt", 64'(STALL_CNT), 64'(exp_stall));
      if (sb.size() != 0) check_head("head");
   endtask

   initial begin
      RESET = 1'b0;
      IF_VALID = 1'b0; IF_INSTRUCTION = '0; IF_PC = '0;
      FLUSH = 1'b0; ID_READY = 1'b0;
      offered = '{instr: 32'd0, pc: 32'd0, sel: 4'd0, en: 1'b0, ill: 1'b0};
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check_reset_values();
      RESET = 1'b1;

      // LUI with decode ready: visible next cycle, popped the cycle after
      ID_READY = 1'b1;
      offer(32'h123450B7, 32'h0, 4'b0000, 1'b1, 1'b0);
      cycle();
      IF_VALID = 1'b0;
      cycle();
      cycle();

      // SLTIU then BGEU while stalled, then hold full
      ID_READY = 1'b0;
      offer(32'h0FF13093, 32'h4, 4'b1010, 1'b1, 1'b0);
      cycle();
      offer(32'h00B57463, 32'h8, 4'b1011, 1'b1, 1'b0);
      cycle();
      IF_VALID = 1'b0;
      cycle();
      cycle();

      // Full: pop with an offered JAL that must not be accepted
      ID_READY = 1'b1;
      offer(32'h0000006F, 32'hC, 4'b0001, 1'b1, 1'b0);
      cycle();

      // Count=1: push ADD while popping BGEU
      offer(32'h00B50533, 32'h10, 4'b0111, 1'b0, 1'b0);
      cycle();

      // Fill with a STORE, then flush with an offer and a pop pending
      ID_READY = 1'b0;
      offer(32'h00A12023, 32'h14, 4'b0100, 1'b1, 1'b0);
      cycle();
      ID_READY = 1'b1;
      FLUSH = 1'b1;
      offer(32'h0000006F, 32'h18, 4'b0001, 1'b1, 1'b0);
      cycle();
      FLUSH = 1'b0;
      IF_VALID = 1'b0;
      cycle();

      // Sustained one-per-cycle stream
      offer(32'h00008067, 32'h20, 4'b0010, 1'b1, 1'b0); cycle();
      offer(32'h00052283, 32'h24, 4'b0010, 1'b1, 1'b0); cycle();
      offer(32'h00000517, 32'h28, 4'b0000, 1'b1, 1'b0); cycle();
      offer(32'h00B56463, 32'h2C, 4'b1011, 1'b1, 1'b0); cycle();
      offer(32'h00100093, 32'h30, 4'b0010, 1'b1, 1'b0); cycle();
      IF_VALID = 1'b0;
      cycle();

      // Illegal opcode, then a long stall to saturate the counter
      ID_READY = 1'b0;
      offer(32'hFFFFFFFF, 32'h34, 4'b0111, 1'b0, 1'b1);
      cycle();
      IF_VALID = 1'b0;
      for (int i = 0; i < STALL_MAX + 3; i++) cycle();

      // Asynchronous reset pulse in the middle of the stall
      RESET = 1'b0;
      #1;
      check_reset_values();
      sb.delete();
      exp_stall = 0;
      #2;
      RESET = 1'b1;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
